// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the segment-character sequencer: default character
// and hold-counter widths, and the sequencer state encoding.
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int CHAR_W_DEF = 7;  // one bit per display segment
    localparam int HOLD_W_DEF = 4;  // hold length in animation frames

    // Sequencer states; the numeric encoding is visible on debug taps.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } seq_state_e;

endpackage

// File: rtl/seg_char_fifo.sv
// -----------------------------------------------------------------------------
// seg_char_fifo
// Synchronous first-word-fall-through FIFO for segment characters.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   flush_i         synchronous clear; overrides push and pop
//   push_i, data_i  write request and data (ignored while full)
//   pop_i           read request (ignored while empty)
//   head_o          oldest stored entry
//   count_o         occupancy, 0..DEPTH
//   full_o, empty_o occupancy flags derived from the registered count
// -----------------------------------------------------------------------------
module seg_char_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
            else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count already
    // guarantee no stale entry is ever read, and this lets it map to RAM.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/seg_char_sequencer.sv
// -----------------------------------------------------------------------------
// seg_char_sequencer
// Queues segment characters and hands them to a display animator one at a
// time, keeping each on screen for at least hold_frames animation frames and
// waiting for the animator to finish before issuing the next one.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   ena           allows a new character to be issued (in-flight hold/drain
//                 still completes when low)
//   tick60        one-cycle pulse per animation frame
//   wr_valid,
//   wr_char       push interface; wr_ready is high while the FIFO is not full
//   flush         synchronous clear of FIFO and sequencer (char_out and
//                 overflow are kept)
//   hold_frames   frames to hold each character, sampled at issue
//   anim_busy     animator still working on the previous character
//   char_avail    one-cycle issue strobe
//   char_out      last issued character, stable until the next issue
//   fifo_count    FIFO occupancy
//   overflow      sticky: a push was attempted while full (cleared by reset)
// -----------------------------------------------------------------------------
module seg_char_sequencer
    import seg_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int CHAR_W = CHAR_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   tick60,
    input  logic                   wr_valid,
    input  logic [CHAR_W-1:0]      wr_char,
    output logic                   wr_ready,
    input  logic                   flush,
    input  logic [HOLD_W-1:0]      hold_frames,
    input  logic                   anim_busy,
    output logic                   char_avail,
    output logic [CHAR_W-1:0]      char_out,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    seq_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CHAR_W-1:0] char_out_q, char_out_d;
    logic              char_avail_q, char_avail_d;
    logic              overflow_q, overflow_d;
    logic              drain_first_q;

    logic [CHAR_W-1:0] fifo_head;
    logic              fifo_pop, fifo_full, fifo_empty;

    seg_char_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CHAR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (wr_valid),
        .data_i  (wr_char),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Registered count only: a pop in the same cycle never frees a slot early.
    assign wr_ready = !fifo_full;

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        char_out_d   = char_out_q;
        char_avail_d = 1'b0;
        fifo_pop     = 1'b0;
        overflow_d   = overflow_q | (wr_valid && !wr_ready && !flush);

        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ena && !fifo_empty && !anim_busy) state_d = ISSUE;
                end
                ISSUE: begin
                    char_avail_d = 1'b1;
                    char_out_d   = fifo_head;
                    fifo_pop     = 1'b1;
                    hold_cnt_d   = hold_frames;
                    state_d      = HOLD;
                end
                HOLD: begin
                    if (hold_cnt_q == '0) state_d    = DRAIN;
                    else if (tick60)      hold_cnt_d = hold_cnt_q - 1'b1;
                end
                DRAIN: begin
                    // The animator raises anim_busy one cycle after the issue
                    // strobe, so the first DRAIN cycle cannot trust it.
                    if (!drain_first_q && !anim_busy) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            char_out_q    <= '0;
            char_avail_q  <= 1'b0;
            overflow_q    <= 1'b0;
            drain_first_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            char_out_q    <= char_out_d;
            char_avail_q  <= char_avail_d;
            overflow_q    <= overflow_d;
            // High during the first cycle spent in DRAIN.
            drain_first_q <= (state_q != DRAIN);
        end
    end

    assign char_avail = char_avail_q;
    assign char_out   = char_out_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_seg_char_sequencer.sv
// -----------------------------------------------------------------------------
// tb_seg_char_sequencer
// Directed scenarios plus randomized traffic for seg_char_sequencer. The
// reference model tracks the queued characters and the display lifetime of
// the current character (hold frames left, drain cycles elapsed).
// -----------------------------------------------------------------------------
module tb_seg_char_sequencer;

    localparam int DEPTH  = 8;
    localparam int CHAR_W = 7;
    localparam int HOLD_W = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena, tick60, wr_valid, flush, anim_busy;
    logic [CHAR_W-1:0] wr_char;
    logic [HOLD_W-1:0] hold_frames;
    logic              wr_ready, char_avail, overflow;
    logic [CHAR_W-1:0] char_out;
    logic [CW-1:0]     fifo_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seg_char_sequencer #(
        .DEPTH  (DEPTH),
        .CHAR_W (CHAR_W),
        .HOLD_W (HOLD_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .tick60      (tick60),
        .wr_valid    (wr_valid),
        .wr_char     (wr_char),
        .wr_ready    (wr_ready),
        .flush       (flush),
        .hold_frames (hold_frames),
        .anim_busy   (anim_busy),
        .char_avail  (char_avail),
        .char_out    (char_out),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    // ---------------- reference model ----------------
    logic [CHAR_W-1:0] m_q[$];
    logic [CHAR_W-1:0] m_cout;
    logic              m_ovf, m_avail;
    bit                m_issue_due;   // issue decided, takes effect next edge
    int                m_hold_left;   // frames left to show; -1 = not holding
    int                m_drain_cyc;   // cycles waited for animator; -1 = not draining

    task automatic model_reset();
        m_q.delete();
        m_cout      = '0;
        m_ovf       = 1'b0;
        m_avail     = 1'b0;
        m_issue_due = 1'b0;
        m_hold_left = -1;
        m_drain_cyc = -1;
    endtask

    task automatic model_edge();
        bit was_full;
        was_full = (m_q.size() == DEPTH);
        m_avail  = 1'b0;
        if (flush) begin
            m_q.delete();
            m_issue_due = 1'b0;
            m_hold_left = -1;
            m_drain_cyc = -1;
            return;
        end
        if (wr_valid && was_full) m_ovf = 1'b1;
        if (m_issue_due) begin
            m_avail     = 1'b1;
            m_cout      = m_q.pop_front();
            m_hold_left = int'(hold_frames);
            m_issue_due = 1'b0;
        end else if (m_hold_left >= 0) begin
            if (m_hold_left == 0) begin
                m_hold_left = -1;
                m_drain_cyc = 0;
            end else if (tick60) begin
                m_hold_left--;
            end
        end else if (m_drain_cyc >= 0) begin
            if (m_drain_cyc >= 1 && !anim_busy) m_drain_cyc = -1;
            else m_drain_cyc++;
        end else if (ena && m_q.size() != 0 && !anim_busy) begin
            m_issue_due = 1'b1;
        end
        if (wr_valid && !was_full) m_q.push_back(wr_char);
    endtask

    // One clock: inputs were set at the previous falling edge; outputs are
    // observed at the next falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        ena = 1'b1; tick60 = 1'b0; wr_valid = 1'b0; wr_char = '0;
        flush = 1'b0; hold_frames = '0; anim_busy = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (char_avail !== 1'b0) $display("FAIL reset_avail: got %b want 0", char_avail); else n_pass++;
        n_total++; if (char_out !== 7'h00) $display("FAIL reset_char: got %h want 00", char_out); else n_pass++;
        n_total++; if (fifo_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", fifo_count); else n_pass++;
        n_total++; if (wr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", wr_ready); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else n_pass++;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_first_issue();
        int ticks = 0;
        bit seen = 0;
        hold_frames = 4'd2;
        wr_valid = 1'b1; wr_char = 7'h3F;
        step();
        wr_valid = 1'b0;
        n_total++; if (fifo_count !== 4'd1) $display("FAIL first_push_count: got %0d want 1", fifo_count); else n_pass++;
        n_total++; if (char_avail !== 1'b0) $display("FAIL first_early1: got %b want 0", char_avail); else n_pass++;
        step();
        n_total++; if (char_avail !== 1'b0) $display("FAIL first_early2: got %b want 0", char_avail); else n_pass++;
        step();
        n_total++; if (char_avail !== 1'b1) $display("FAIL first_latency: got %b want 1", char_avail); else n_pass++;
        n_total++; if (char_out !== 7'h3F) $display("FAIL first_char: got %h want 3f", char_out); else n_pass++;
        n_total++; if (fifo_count !== 4'd0) $display("FAIL first_pop_count: got %0d want 0", fifo_count); else n_pass++;
        // Queue a second character and count frame ticks until it issues.
        for (int i = 0; i < 60 && !seen; i++) begin
            wr_valid = (i == 0); wr_char = 7'h06;
            tick60 = (i % 4 == 1);
            step();
            if (tick60) ticks++;
            if (char_avail) seen = 1;
        end
        wr_valid = 1'b0; tick60 = 1'b0;
        n_total++; if (!seen) $display("FAIL second_timeout: got no issue want issue within 60 cycles"); else n_pass++;
        if (seen) begin
            n_total++; if (ticks < 2) $display("FAIL second_hold: got %0d ticks want >=2", ticks); else n_pass++;
            n_total++; if (char_out !== 7'h06) $display("FAIL second_char: got %h want 06", char_out); else n_pass++;
        end
    endtask

    task automatic test_overflow();
        ena = 1'b0;
        flush = 1'b1; step(); flush = 1'b0;
        n_total++; if (fifo_count !== 4'd0) $display("FAIL ovf_flush_count: got %0d want 0", fifo_count); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1; wr_char = CHAR_W'(8'h10 + i);
            step();
        end
        n_total++; if (fifo_count !== 4'd8) $display("FAIL ovf_full_count: got %0d want 8", fifo_count); else n_pass++;
        n_total++; if (wr_ready !== 1'b0) $display("FAIL ovf_full_ready: got %b want 0", wr_ready); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_early: got %b want 0", overflow); else n_pass++;
        wr_char = 7'h18;
        step();
        wr_valid = 1'b0;
        n_total++; if (fifo_count !== 4'd8) $display("FAIL ovf_ninth_count: got %0d want 8", fifo_count); else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else n_pass++;
        n_total++; if (wr_ready !== 1'b0) $display("FAIL ovf_ninth_ready: got %b want 0", wr_ready); else n_pass++;
    endtask

    task automatic test_full_pop_push();
        hold_frames = 4'd0; anim_busy = 1'b0; ena = 1'b1;
        step();
        n_total++; if (char_avail !== 1'b0) $display("FAIL fpp_pre_avail: got %b want 0", char_avail); else n_pass++;
        // Push during the cycle in which the head is popped.
        wr_valid = 1'b1; wr_char = 7'h55;
        step();
        wr_valid = 1'b0;
        n_total++; if (fifo_count !== 4'd7) $display("FAIL fpp_count: got %0d want 7", fifo_count); else n_pass++;
        n_total++; if (char_avail !== 1'b1) $display("FAIL fpp_avail: got %b want 1", char_avail); else n_pass++;
        n_total++; if (char_out !== 7'h10) $display("FAIL fpp_char: got %h want 10", char_out); else n_pass++;
    endtask

    task automatic test_busy_drain();
        int pulses = 0;
        int n = 0;
        bit seen = 0;
        anim_busy = 1'b1;
        repeat (20) begin
            step();
            if (char_avail) pulses++;
        end
        n_total++; if (pulses != 0) $display("FAIL busy_blocked: got %0d issues want 0", pulses); else n_pass++;
        anim_busy = 1'b0;
        for (int i = 1; i <= 10 && !seen; i++) begin
            step();
            if (char_avail) begin seen = 1; n = i; end
        end
        n_total++; if (!seen) $display("FAIL busy_timeout: got no issue want issue within 10 cycles"); else n_pass++;
        if (seen) begin
            n_total++; if (n < 2) $display("FAIL busy_gap: got issue %0d edges after fall want >=2", n); else n_pass++;
            n_total++; if (char_out !== 7'h11) $display("FAIL busy_char: got %h want 11", char_out); else n_pass++;
        end
    endtask

    task automatic test_flush();
        int pulses = 0;
        flush = 1'b1; step(); flush = 1'b0;
        hold_frames = 4'd5; tick60 = 1'b0; anim_busy = 1'b0; ena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_char = CHAR_W'(8'h21 + i);
            step();
        end
        wr_valid = 1'b0;
        step(); step();
        n_total++; if (fifo_count !== 4'd3) $display("FAIL flush_pre_count: got %0d want 3", fifo_count); else n_pass++;
        flush = 1'b1; step(); flush = 1'b0;
        n_total++; if (fifo_count !== 4'd0) $display("FAIL flush_count: got %0d want 0", fifo_count); else n_pass++;
        n_total++; if (char_avail !== 1'b0) $display("FAIL flush_avail: got %b want 0", char_avail); else n_pass++;
        n_total++; if (char_out !== 7'h21) $display("FAIL flush_char_kept: got %h want 21", char_out); else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL flush_ovf_kept: got %b want 1", overflow); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            tick60 = (i % 2 == 1);
            step();
            if (char_avail) pulses++;
        end
        tick60 = 1'b0;
        n_total++; if (pulses != 0) $display("FAIL flush_quiet: got %0d issues want 0", pulses); else n_pass++;
        // Sequencer must be back in IDLE: a fresh push issues with base latency.
        wr_valid = 1'b1; wr_char = 7'h7F;
        step();
        wr_valid = 1'b0;
        step();
        n_total++; if (char_avail !== 1'b0) $display("FAIL flush_idle_early: got %b want 0", char_avail); else n_pass++;
        step();
        n_total++; if (char_avail !== 1'b1) $display("FAIL flush_idle_issue: got %b want 1", char_avail); else n_pass++;
        n_total++; if (char_out !== 7'h7F) $display("FAIL flush_idle_char: got %h want 7f", char_out); else n_pass++;
    endtask

    task automatic test_async_reset();
        wr_valid = 1'b1; wr_char = 7'h2A;
        step();
        wr_valid = 1'b0;
        n_total++; if (fifo_count !== 4'd1) $display("FAIL areset_pre_count: got %0d want 1", fifo_count); else n_pass++;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (char_avail !== 1'b0) $display("FAIL areset_avail: got %b want 0", char_avail); else n_pass++;
        n_total++; if (char_out !== 7'h00) $display("FAIL areset_char: got %h want 00", char_out); else n_pass++;
        n_total++; if (fifo_count !== 4'd0) $display("FAIL areset_count: got %0d want 0", fifo_count); else n_pass++;
        n_total++; if (wr_ready !== 1'b1) $display("FAIL areset_ready: got %b want 1", wr_ready); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL areset_ovf: got %b want 0", overflow); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ena         = ($urandom_range(0, 7) != 0);
            tick60      = ($urandom_range(0, 3) == 0);
            wr_valid    = ($urandom_range(0, 1) == 1);
            wr_char     = CHAR_W'($urandom);
            flush       = ($urandom_range(0, 63) == 0);
            hold_frames = HOLD_W'($urandom_range(0, 3));
            anim_busy   = ($urandom_range(0, 3) == 0);
            step();
            n_total++; if (char_avail !== m_avail) $display("FAIL rnd_avail cyc %0d: got %b want %b", cyc, char_avail, m_avail); else n_pass++;
            n_total++; if (char_out !== m_cout) $display("FAIL rnd_char cyc %0d: got %h want %h", cyc, char_out, m_cout); else n_pass++;
            n_total++; if (fifo_count !== CW'(m_q.size())) $display("FAIL rnd_count cyc %0d: got %0d want %0d", cyc, fifo_count, m_q.size()); else n_pass++;
            n_total++; if (wr_ready !== (m_q.size() != DEPTH)) $display("FAIL rnd_ready cyc %0d: got %b want %b", cyc, wr_ready, m_q.size() != DEPTH); else n_pass++;
            n_total++; if (overflow !== m_ovf) $display("FAIL rnd_ovf cyc %0d: got %b want %b", cyc, overflow, m_ovf); else n_pass++;
        end
        flush = 1'b0; wr_valid = 1'b0; tick60 = 1'b0; anim_busy = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_issue();
        test_overflow();
        test_full_pop_push();
        test_busy_drain();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
